ports_ctrl: RTL

PORTS_CTRL -- requirements
Module: ports_ctrl

---
 rtl/ports_ctrl_pkg.sv | 61 ++++++
 rtl/pads_if.sv | 25 ++
 rtl/port_sync.sv | 26 ++
 rtl/ports_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/ports_ctrl_pkg.sv
// Shared types for the GPIO port controller: pad types, the board pinout
// and the register address map.
package ports_ctrl_pkg;

  localparam int MAXPADS = 32;

  typedef enum logic [1:0] {
    PADTYPE_GPIO   = 2'd0,
    PADTYPE_VDD    = 2'd1,
    PADTYPE_VSS    = 2'd2,
    PADTYPE_ANALOG = 2'd3
  } t_padtype;

  typedef struct packed {
    t_padtype padtype;
  } t_pin;

  // Pad i lives at index i, matching the 1-based pad numbering of pads_if.
  typedef t_pin [MAXPADS:1] t_pinout;

  typedef enum logic [3:0] {
    REG_DIR     = 4'd0,
    REG_OUT     = 4'd1,
    REG_OUTSET  = 4'd2,
    REG_OUTCLR  = 4'd3,
    REG_OUTTGL  = 4'd4,
    REG_PULLUP  = 4'd5,
    REG_PULLDN  = 4'd6,
    REG_SLEW    = 4'd7,
    REG_INEN    = 4'd8,
    REG_IN      = 4'd9,
    REG_IRQRISE = 4'd10,
    REG_IRQFALL = 4'd11,
    REG_IRQFLAG = 4'd12
  } t_portreg;

  function automatic t_pinout pinout_all_gpio();
    t_pinout p;
    for (int i = 1; i <= MAXPADS; i++) p[i].padtype = PADTYPE_GPIO;
    return p;
  endfunction

  // Derive a pinout variant with one pad retyped (e.g. a supply pad).
  function automatic t_pinout pinout_set(input t_pinout base, input int pad,
                                         input t_padtype pt);
    t_pinout p;
    p = base;
    p[pad].padtype = pt;
    return p;
  endfunction

  // Register-bit mask (bit i-1 = pad i) of pads that are GPIO and present.
  function automatic logic [MAXPADS-1:0] gpio_mask(input t_pinout p, input int n);
    logic [MAXPADS-1:0] m;
    for (int i = 1; i <= MAXPADS; i++) m[i-1] = (i <= n) && (p[i].padtype == PADTYPE_GPIO);
    return m;
  endfunction

  localparam t_pinout pinout = pinout_all_gpio();

endpackage

// File: rtl/pads_if.sv
// Pad-ring control bundle; the controller drives the pad controls and
// samples the pad input values.
interface pads_if
  import ports_ctrl_pkg::*;
#(
  parameter int NUMPADS = 16
);
  logic [1:NUMPADS] pullup_en;
  logic [1:NUMPADS] pulldown_en;
  logic [1:NUMPADS] output_en;
  logic [1:NUMPADS] output_val;
  logic [1:NUMPADS] slew_limit_en;
  logic [1:NUMPADS] input_en;
  logic [1:NUMPADS] input_val;

  modport mp_ports (
    output pullup_en, pulldown_en, output_en, output_val, slew_limit_en, input_en,
    input  input_val
  );

  modport mp_pads (
    input  pullup_en, pulldown_en, output_en, output_val, slew_limit_en, input_en,
    output input_val
  );
endinterface

// File: rtl/port_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
module port_sync
  import ports_ctrl_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage presents a settled value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ports_ctrl.sv
// GPIO port controller: register file driving pad controls, synchronized
// pad inputs with rise/fall edge interrupts and a registered read port.
module ports_ctrl
  import ports_ctrl_pkg::*;
#(
  parameter int      NUMPADS = 16,
  parameter t_pinout PINOUT  = pinout
) (
  input  logic        clk,
  input  logic        rst,
  pads_if.mp_ports    padsif,
  input  logic [3:0]  addr,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  input  logic        rd_en,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        irq
);

  // Non-GPIO pads have their bits forced to 0 in every register.
  localparam logic [MAXPADS-1:0] GPIO_ALL = gpio_mask(PINOUT, NUMPADS);
  localparam logic [NUMPADS-1:0] GPIO     = GPIO_ALL[NUMPADS-1:0];

  t_portreg           reg_sel;
  logic [NUMPADS-1:0] wd;
  logic               unused_wdata;
  logic [NUMPADS-1:0] dir_r, out_r, pu_r, pd_r, slew_r, inen_r;
  logic [NUMPADS-1:0] rise_r, fall_r, flag_r;
  logic [NUMPADS-1:0] in_gated, in_sync, in_prev;
  logic [NUMPADS-1:0] flag_set, flag_clr;
  logic [NUMPADS-1:0] rd_val;
  logic [31:0]        rd_word;

  assign reg_sel      = t_portreg'(addr);
  assign wd           = wdata[NUMPADS-1:0] & GPIO;
  assign unused_wdata = ^wdata;

  // Configuration registers; OUT also takes set/clear/toggle aliases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_r  <= '0;
      out_r  <= '0;
      pu_r   <= '0;
      pd_r   <= '0;
      slew_r <= '0;
      inen_r <= GPIO;
      rise_r <= '0;
      fall_r <= '0;
    end else if (wr_en) begin
      case (reg_sel)
        REG_DIR:     dir_r  <= wd;
        REG_OUT:     out_r  <= wd;
        REG_OUTSET:  out_r  <= out_r | wd;
        REG_OUTCLR:  out_r  <= out_r & ~wd;
        REG_OUTTGL:  out_r  <= out_r ^ wd;
        REG_PULLUP:  pu_r   <= wd;
        REG_PULLDN:  pd_r   <= wd;
        REG_SLEW:    slew_r <= wd;
        REG_INEN:    inen_r <= wd;
        REG_IRQRISE: rise_r <= wd;
        REG_IRQFALL: fall_r <= wd;
        default:     ;
      endcase
    end
  end

  // Pad mapping: pad i <-> register bit i-1. Gating before the synchronizer
  // means disabling a high input looks like a real falling edge.
  for (genvar i = 1; i <= NUMPADS; i++) begin : g_pad
    assign padsif.output_en[i]     = dir_r[i-1];
    assign padsif.output_val[i]    = out_r[i-1];
    assign padsif.pullup_en[i]     = pu_r[i-1];
    assign padsif.pulldown_en[i]   = pd_r[i-1] & ~pu_r[i-1];
    assign padsif.slew_limit_en[i] = slew_r[i-1];
    assign padsif.input_en[i]      = inen_r[i-1];
    assign in_gated[i-1]           = padsif.input_val[i] & inen_r[i-1];
  end

  port_sync #(.WIDTH(NUMPADS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in_gated),
    .q   (in_sync)
  );

  assign flag_set = (in_sync & ~in_prev & rise_r) | (~in_sync & in_prev & fall_r);
  assign flag_clr = (wr_en && (reg_sel == REG_IRQFLAG)) ? wd : '0;

  // Edge history, sticky flags (set beats W1C) and the registered irq level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_prev <= '0;
      flag_r  <= '0;
      irq     <= 1'b0;
    end else begin
      in_prev <= in_sync;
      flag_r  <= (flag_r & ~flag_clr) | flag_set;
      irq     <= |flag_r;
    end
  end

  // Read mux over current register contents (pre-write on a same-cycle write).
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_DIR:     rd_val = dir_r;
      REG_OUT:     rd_val = out_r;
      REG_PULLUP:  rd_val = pu_r;
      REG_PULLDN:  rd_val = pd_r;
      REG_SLEW:    rd_val = slew_r;
      REG_INEN:    rd_val = inen_r;
      REG_IN:      rd_val = in_sync;
      REG_IRQRISE: rd_val = rise_r;
      REG_IRQFALL: rd_val = fall_r;
      REG_IRQFLAG: rd_val = flag_r;
      default:     rd_val = '0;
    endcase
    rd_word = '0;
    rd_word[NUMPADS-1:0] = rd_val;
  end

  // Registered read port; rdata holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) rdata <= rd_word;
    end
  end

endmodule
